// File: rtl/wombat_frame_sync_if.sv
// wombat_frame_sync_if
//   Bundles the receive-word input and the frame/status outputs of the
//   wombat byte-to-frame assembler.
//   master : the UART-receiver side. It drives i_data/i_dv and reads the results.
//   slave  : the frame assembler. It reads i_data/i_dv and drives the results.
//   Signals:
//     i_data        received word, sampled on an i_dv rising edge
//     i_dv          receiver data-valid level
//     o_data        last good frame, held until the next good frame
//     o_dv          one-cycle pulse when a good frame is available
//     o_timeout     one-cycle pulse when a partial frame is dropped on idle
//     o_cksum_err   one-cycle pulse when a frame is dropped on bad checksum
//     o_frame_count good frames emitted (wraps)
//     o_drop_count  dropped frames (saturates)
//     o_busy        partial frame currently held
interface wombat_frame_sync_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int FRAME_WORDS = 6,
  parameter int CNT_WIDTH   = 16
);
  logic [WORD_WIDTH-1:0]             i_data;
  logic                              i_dv;
  logic [WORD_WIDTH*FRAME_WORDS-1:0] o_data;
  logic                              o_dv;
  logic                              o_timeout;
  logic                              o_cksum_err;
  logic [CNT_WIDTH-1:0]              o_frame_count;
  logic [CNT_WIDTH-1:0]              o_drop_count;
  logic                              o_busy;

  modport master (
    output i_data, i_dv,
    input  o_data, o_dv, o_timeout, o_cksum_err,
           o_frame_count, o_drop_count, o_busy
  );

  modport slave (
    input  i_data, i_dv,
    output o_data, o_dv, o_timeout, o_cksum_err,
           o_frame_count, o_drop_count, o_busy
  );
endinterface

// File: rtl/wombat_frame_sync.sv
// wombat_frame_sync
//   Assembles words from the UART receiver into fixed-length command frames.
//   An optional trailing XOR checksum word is verified and never stored.
//   Partial frames are dropped after TIMEOUT idle cycles, so a truncated host
//   transfer cannot misalign later frames.
//   Ports:
//     clk      clock
//     i_reset  asynchronous active-low reset
//     bus      wombat_frame_sync_if.slave: i_data/i_dv in; o_data, o_dv,
//              o_timeout, o_cksum_err, o_frame_count, o_drop_count, o_busy out
module wombat_frame_sync #(
  parameter int WORD_WIDTH    = 8,
  parameter int FRAME_WORDS   = 6,
  parameter int CHECKSUM_EN   = 0,
  parameter int TIMEOUT       = 4096,
  parameter int LITTLE_ENDIAN = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  i_reset,
  wombat_frame_sync_if.slave    bus
);

  localparam int FW = WORD_WIDTH * FRAME_WORDS;
  localparam int N  = FRAME_WORDS + ((CHECKSUM_EN != 0) ? 1 : 0);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    dv_q;
  logic [IW-1:0]           idx_q, idx_d, idx_cur;
  logic [TW-1:0]           timer_q, timer_d;
  logic [WORD_WIDTH-1:0]   xor_q, xor_d;
  logic [FW-1:0]           shreg_q, shreg_d;
  logic                    accept, is_last, is_cksum_word;

  logic                    done_vld_d, cksum_ok_d, timeout_d;
  logic                    done_vld_p0, cksum_ok_p0;

  logic [FW-1:0]           data_p1;
  logic                    frame_vld_p1, timeout_p1, cksum_err_p1;
  logic [CNT_WIDTH-1:0]    frame_cnt_q, drop_cnt_q;

  // Places a new payload word into the frame register according to the
  // configured byte order; after FRAME_WORDS shifts the first word sits in
  // the MSBs (big endian) or the LSBs (little endian).
  function automatic logic [FW-1:0] shift_in(input logic [FW-1:0]         cur,
                                             input logic [WORD_WIDTH-1:0] w);
    if (LITTLE_ENDIAN != 0)
      shift_in = (cur >> WORD_WIDTH) | (FW'(w) << (FW - WORD_WIDTH));
    else
      shift_in = (cur << WORD_WIDTH) | FW'(w);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
    sat_inc = (inc && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  // A word is taken only on a rising edge of the receiver's level valid.
  assign accept        = bus.i_dv & ~dv_q;
  assign idx_cur       = (state_q == COLLECT) ? idx_q : '0;
  assign is_last       = (idx_cur == LAST_IDX);
  assign is_cksum_word = (CHECKSUM_EN != 0) && is_last;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    xor_d      = xor_q;
    shreg_d    = shreg_q;
    done_vld_d = 1'b0;
    cksum_ok_d = 1'b0;
    timeout_d  = 1'b0;

    if (accept) begin
      // An accepted word always wins over a timer expiring on the same cycle.
      timer_d = '0;
      if (!is_cksum_word) begin
        shreg_d = shift_in(shreg_q, bus.i_data);
        // xor_q is zero whenever IDLE, so the first word needs no special case.
        xor_d   = xor_q ^ bus.i_data;
      end
      if (is_last) begin
        state_d    = IDLE;
        idx_d      = '0;
        xor_d      = '0;
        done_vld_d = 1'b1;
        cksum_ok_d = (CHECKSUM_EN == 0) || (bus.i_data == xor_q);
      end else begin
        state_d = COLLECT;
        idx_d   = idx_cur + 1'b1;
      end
    end else if (state_q == COLLECT) begin
      if (timer_q == TIMER_LAST) begin
        state_d   = IDLE;
        idx_d     = '0;
        xor_d     = '0;
        timer_d   = '0;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Stage p0: word capture, frame state, completion flags
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      // dv_q starts high so a valid level held through reset is not a word.
      dv_q        <= 1'b1;
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      xor_q       <= '0;
      shreg_q     <= '0;
      done_vld_p0 <= 1'b0;
      cksum_ok_p0 <= 1'b0;
    end else begin
      dv_q        <= bus.i_dv;
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      xor_q       <= xor_d;
      shreg_q     <= shreg_d;
      done_vld_p0 <= done_vld_d;
      cksum_ok_p0 <= cksum_ok_d;
    end
  end

  // Stage p1: frame publication, status pulses and counters.
  // shreg_q is safe to copy here: the edge detector guarantees no word is
  // accepted on the cycle right after the final one.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      data_p1      <= '0;
      frame_vld_p1 <= 1'b0;
      timeout_p1   <= 1'b0;
      cksum_err_p1 <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      frame_vld_p1 <= done_vld_p0 & cksum_ok_p0;
      cksum_err_p1 <= done_vld_p0 & ~cksum_ok_p0;
      timeout_p1   <= timeout_d;
      if (done_vld_p0 && cksum_ok_p0) begin
        data_p1     <= shreg_q;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      drop_cnt_q <= sat_inc(sat_inc(drop_cnt_q, timeout_d),
                            done_vld_p0 & ~cksum_ok_p0);
    end
  end

  assign bus.o_data        = data_p1;
  assign bus.o_dv          = frame_vld_p1;
  assign bus.o_timeout     = timeout_p1;
  assign bus.o_cksum_err   = cksum_err_p1;
  assign bus.o_frame_count = frame_cnt_q;
  assign bus.o_drop_count  = drop_cnt_q;
  assign bus.o_busy        = (state_q == COLLECT);

endmodule

// File: doc/wombat_frame_sync.md
# wombat_frame_sync

Byte-to-frame assembler between the UART receiver and the command controller in the wombat command path. It collects received bytes into fixed-length command frames, optionally checks a trailing XOR checksum, and emits each complete frame as a one-cycle pulse. Partial frames are discarded after an inter-byte timeout, so a glitched or truncated host transfer cannot permanently misalign the parser. Error and frame counters are exported for status readback.

## Interface

Parameters:

- WORD_WIDTH, 8: bits per received byte/word.
- FRAME_WORDS, 6: payload words per frame (command + address + REG_WIDTH value words).
- CHECKSUM_EN, 0: 1 = one extra trailing checksum word per frame (XOR of all payload words).
- TIMEOUT, 4096: idle clock cycles after an accepted word before a partial frame is dropped. Must be ≥ 2.
- LITTLE_ENDIAN, 0: 0 = first word lands in the MSBs of o_data; 1 = first word lands in the LSBs.
- CNT_WIDTH, 16: width of the status counters.

Ports:

- clk, input, 1: clock.
- i_reset, input, 1: reset. Asynchronous, active-low.
- i_data, input, WORD_WIDTH: received word. Sampled when an i_dv rising edge is detected.
- i_dv, input, 1: receiver data-valid (level). Its rising edge marks a new word.
- o_data, output, WORD_WIDTH*FRAME_WORDS: last good frame. Held until the next good frame.
- o_dv, output, 1: one-cycle pulse, frame valid.
- o_timeout, output, 1: one-cycle pulse, partial frame dropped on timeout.
- o_cksum_err, output, 1: one-cycle pulse, frame dropped on checksum mismatch.
- o_frame_count, output, CNT_WIDTH: good frames emitted. Wraps.
- o_drop_count, output, CNT_WIDTH: frames dropped (timeout + checksum). Saturates at all-ones.
- o_busy, output, 1: high while a partial frame is held (state COLLECT).

## Operation

- Edge detect: dv_q registers i_dv. A word is accepted on each clock where i_dv=1 and dv_q=0.
  - dv_q resets to 1, so an i_dv held high through reset release is not taken as a word.
- Frame length N = FRAME_WORDS + CHECKSUM_EN. A word index counter runs 0..N-1.
- Shift register:
  - Payload words shift in per LITTLE_ENDIAN.
  - A running XOR accumulates the payload words.
  - The checksum word is compared against the XOR and is never stored in o_data.
- States:
  - IDLE: on an accepted word, store it, set index=1, clear the timer, and go to COLLECT. If N=1, complete immediately instead.
  - COLLECT: on an accepted word, store it, increment index, and clear the timer. Otherwise the timer increments.
    - Word N-1 accepted: go to IDLE and evaluate completion.
    - Timer reaches TIMEOUT-1 with no accepted word: go to IDLE, pulse o_timeout, increment o_drop_count, and clear index and XOR.
- Completion, on the cycle word N-1 is accepted:
  - If CHECKSUM_EN=0 or the checksum matches: latch o_data, pulse o_dv, increment o_frame_count.
  - Otherwise: pulse o_cksum_err, increment o_drop_count, and leave o_data unchanged.
- Simultaneous events:
  - An accepted word on the same cycle the timer would expire wins: it is stored, the timer clears, and there is no timeout.
  - An o_drop_count increment at all-ones holds the count at all-ones.
- Reset (asynchronous, mid-frame included): state IDLE; index, timer, XOR and shift register cleared; o_data=0; o_dv, o_timeout, o_cksum_err, o_busy = 0; both counters = 0. Any partial frame is lost without a count.

## Timing

- Accepted-word latency: i_dv rises before clock edge k; the word is captured at edge k (dv_q is still 0).
- Frame latency: final word accepted at edge k; o_dv (or o_cksum_err) is high from edge k+1 to edge k+2.
  - o_data and o_frame_count update at edge k+1.
- Timeout: last word accepted at edge k; o_timeout is high from edge k+TIMEOUT to edge k+TIMEOUT+1.
- A new frame may start on the word immediately following completion. No dead cycles.
- All outputs are registered. There are no combinational input-to-output paths.
- i_data must be stable in the cycle i_dv rises. The UART receiver guarantees this.

## Test plan

- Good frame, defaults: send bytes 01 02 A0 B1 C2 D3 -> one o_dv pulse, o_data=0x0102A0B1C2D3, o_frame_count=1, o_busy low after.
- LITTLE_ENDIAN=1, same bytes -> o_data=0xD3C2B1A00201.
- Timeout, TIMEOUT=16: send 3 bytes, then idle -> o_timeout exactly 16 cycles after the 3rd byte, o_drop_count=1. Then a full 6-byte frame -> o_dv with correct data; no misalignment.
- Race: 6th byte accepted on the exact cycle the timer hits TIMEOUT-1 -> o_dv, no o_timeout, o_drop_count unchanged.
- CHECKSUM_EN=1: frame 01 02 03 04 05 06 + 07 -> o_dv. Same frame + 00 -> o_cksum_err, o_data unchanged, o_drop_count+1.
- Async reset asserted mid-frame (after 4 bytes) with i_dv held high across release -> all outputs 0, no word accepted until i_dv falls and rises. Next 6 bytes yield a correct frame.
